// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver with double-buffered frame update.
// Shadow data is committed to the visible buffer only at a frame wrap, so a frame never tears.
module seg7_scan #(
  parameter int SCAN_BIT = 16,
  parameter int BLANK_LZ = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] clkdiv,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  dp,
  input  logic        en,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        frame
);

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'b1000000;
      4'h1: pat = 7'b1111001;
      4'h2: pat = 7'b0100100;
      4'h3: pat = 7'b0110000;
      4'h4: pat = 7'b0011001;
      4'h5: pat = 7'b0010010;
      4'h6: pat = 7'b0000010;
      4'h7: pat = 7'b1111000;
      4'h8: pat = 7'b0000000;
      4'h9: pat = 7'b0010000;
      4'hA: pat = 7'b0001000;
      4'hB: pat = 7'b0000011;
      4'hC: pat = 7'b1000110;
      4'hD: pat = 7'b0100001;
      4'hE: pat = 7'b0000110;
      default: pat = 7'b0001110;
    endcase
    return pat;
  endfunction

  logic        prev_q, prev_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] shadow_data_q, shadow_data_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;
  logic [15:0] active_data_q, active_data_d;
  logic [3:0]  active_dp_q, active_dp_d;
  logic        pending_q, pending_d;
  logic        frame_q, frame_d;
  logic [3:0]  an_q, an_d;
  logic [7:0]  seg_q, seg_d;

  logic        tick;
  logic        wrap;
  logic [3:0]  nib;
  logic        lead_zero;
  logic        clkdiv_unused;

  // Only one divider bit is consumed; the rest of the bus is intentionally ignored.
  assign clkdiv_unused = ^clkdiv;

  always_comb begin
    prev_d        = clkdiv[SCAN_BIT];
    tick          = clkdiv[SCAN_BIT] & ~prev_q;
    wrap          = tick && (idx_q == 2'd3);
    idx_d         = tick ? idx_q + 2'd1 : idx_q;
    frame_d       = wrap;

    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    active_data_d = active_data_q;
    active_dp_d   = active_dp_q;
    pending_d     = pending_q;

    // Commit reads the shadow as it was before this edge; a coincident load re-arms pending.
    if (wrap && pending_q) begin
      active_data_d = shadow_data_q;
      active_dp_d   = shadow_dp_q;
      pending_d     = 1'b0;
    end
    if (load) begin
      shadow_data_d = data;
      shadow_dp_d   = dp;
      pending_d     = 1'b1;
    end

    nib = active_data_q[{idx_q, 2'b00} +: 4];
    case (idx_q)
      2'd1:    lead_zero = (active_data_q[15:4] == 12'h000);
      2'd2:    lead_zero = (active_data_q[15:8] == 8'h00);
      2'd3:    lead_zero = (active_data_q[15:12] == 4'h0);
      default: lead_zero = 1'b0;
    endcase

    if (en) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = {~active_dp_q[idx_q],
               ((BLANK_LZ != 0) && lead_zero) ? 7'b1111111 : hex7(nib)};
    end else begin
      an_d  = 4'b1111;
      seg_d = 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // prev tracks the divider even in reset so release never fakes an edge.
      prev_q        <= clkdiv[SCAN_BIT];
      idx_q         <= 2'd0;
      shadow_data_q <= 16'h0000;
      shadow_dp_q   <= 4'h0;
      active_data_q <= 16'h0000;
      active_dp_q   <= 4'h0;
      pending_q     <= 1'b0;
      frame_q       <= 1'b0;
      an_q          <= 4'b1111;
      seg_q         <= 8'hFF;
    end else begin
      prev_q        <= prev_d;
      idx_q         <= idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      active_data_q <= active_data_d;
      active_dp_q   <= active_dp_d;
      pending_q     <= pending_d;
      frame_q       <= frame_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign frame = frame_q;

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter SCAN_BIT, default 16, index of the clkdiv bit whose rising edge advances the scan (legal 0..31).
REQ-002 Parameter BLANK_LZ, default 1, 1 enables leading-zero blanking.
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 clkdiv  input  32  free-running divider count from the upstream clock divider stage.
REQ-006 load  input  1  one-cycle strobe, captures data/dp into the shadow register.
REQ-007 data  input  16  four hex digits, nibble k drives digit k (digit 0 = rightmost).
REQ-008 dp  input  4  decimal point per digit, 1 = lit.
REQ-009 en  input  1  display enable, 0 = all digits dark.
REQ-010 an  output  4  digit anodes, active-low one-hot, registered.
REQ-011 seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low, registered.
REQ-012 frame  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 The block SHALL hold prev = clkdiv[SCAN_BIT] sampled every cycle; tick SHALL be true in a cycle where clkdiv[SCAN_BIT]=1 and prev=0.
REQ-014 On tick, the 2-bit digit index idx SHALL increment modulo 4 (3 -> 0 wraps).
REQ-015 On load, shadow_data <= data, shadow_dp <= dp, and pending <= 1.
REQ-016 On a tick with idx=3 (wrap), if pending=1, active_data/active_dp <= shadow values as held before this edge, and pending <= 0 unless load is also high this cycle.
REQ-017 Load coincident with a wrap commit: the commit SHALL use the old shadow; the new data SHALL go to shadow with pending=1, shown at the next wrap.
REQ-018 Multiple loads within one frame: only the last one SHALL be committed.
REQ-019 frame SHALL pulse high for exactly the cycle after each wrap tick (registered).
REQ-020 an/seg SHALL update one clock after idx/active change: an = ~(1<<idx); seg[6:0] = hex pattern of active_data nibble idx; seg[7] = ~active_dp[idx].
REQ-021 Hex patterns (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-022 BLANK_LZ=1: digit k (k>=1) SHALL show seg[6:0]=1111111 when nibbles k..3 of active_data are all zero; digit 0 SHALL never be blanked; dp unaffected by blanking.
REQ-023 en=0: an=1111, seg=11111111 from the next clock; idx, commit and frame SHALL continue unaffected.
REQ-024 Each digit SHALL be driven for 2^(SCAN_BIT+1) clocks; frame period 2^(SCAN_BIT+3) clocks.

Reset
REQ-025 While rst_n=0 (sampled on clk): idx=0, pending=0, shadow and active data/dp=0, frame=0, an=1111, seg=11111111; reset overrides load and tick.
REQ-026 During reset prev SHALL load clkdiv[SCAN_BIT], so no tick occurs on the first cycle after release even if the bit is already 1.
REQ-027 After reset release, the first driven output SHALL be digit 0 showing 0 (seg=11000000) one clock after release with en=1.

Verification (SCAN_BIT=2, clkdiv from a counter)
REQ-028 Reset release, en=1, no load -> an=1110, seg=11000000; digits 1..3 blank (seg=11111111) as idx advances every 8 clocks.
REQ-029 load data=16'h12AF, dp=4'b0100 mid-frame -> display unchanged until wrap; after wrap digit0 seg=10001110 (F), digit1 10001000 (A), digit2 00100100 (2 with dp), digit3 11111001 (1).
REQ-030 BLANK_LZ=1, data=16'h0050 -> digit3,digit2 blank, digit1 shows 5 (10010010), digit0 shows 0 (11000000); data=16'h0000 -> only digit0 lit.
REQ-031 load pulsed in the same cycle as a wrap tick with data=16'h0001 after pending 16'h0002 -> next frame shows 2, following frame shows 1; frame pulses once per 32 clocks.
REQ-032 rst_n low for one cycle mid-frame with clkdiv[2]=1 at release -> all state cleared, no tick on the cycle after release, idx advances only on the next real rising edge.
REQ-033 en toggled 1->0->1 -> an=1111/seg=FF within one clock of en=0; on en=1 the output resumes at the current idx with no frame phase lost.
